// File: rtl/msg_pkg.sv
// msg_pkg: shared constants and types for the message scroller.
//   SYM_W / BUF_DEPTH / ADDR_W : symbol width, buffer depth and buffer address width
//   SYM_BLANK / SYM_DASH       : display codes for a blank digit and a dash
//   state_t                    : scroller FSM encoding
//   next_idx()                 : advance a buffer index by one, modulo the message length
package msg_pkg;

  localparam int SYM_W     = 5;
  localparam int BUF_DEPTH = 16;
  localparam int ADDR_W    = 4;

  localparam logic [SYM_W-1:0] SYM_BLANK = 5'h12;
  localparam logic [SYM_W-1:0] SYM_DASH  = 5'h11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // last is the message length minus one. idx never exceeds last, so
  // a compare replaces a real modulo.
  function automatic logic [ADDR_W-1:0] next_idx(input logic [ADDR_W-1:0] idx,
                                                 input logic [ADDR_W-1:0] last);
    return (idx == last) ? '0 : idx + 4'd1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler producing a one-cycle scroll tick every DIV enabled cycles.
//   clk, reset : clock, asynchronous active-high reset
//   en         : count enable; the count holds its value while low
//   clr        : synchronous clear, takes priority over counting
//   tick       : high in the cycle the count equals DIV-1 (while enabled)
module tick_gen #(
  parameter int DIV = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/msg_scroller.sv
// msg_scroller: scrolls a message of 1..16 symbols across three display digits.
//   clk, reset                : clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data   : message buffer write port (usable in any state)
//   len                       : message length minus one, sampled on start
//   start, stop               : one-cycle pulses; stop wins over start
//   pause                     : level; freezes scrolling while high
//   hex2, hex1, hex0          : registered symbol codes, left to right
//   dp, en                    : registered decimal points and digit enables
//   busy                      : high in SCROLL or HOLD
//   wrap                      : one-cycle pulse after a tick that wrapped the position
//   state_dbg                 : current FSM state
//   dir (SCROLL_REVERSE_EN)   : when the macro is defined, dir=1 scrolls backwards
module msg_scroller
  import msg_pkg::*;
#(
  parameter int DIV   = 12500000,
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [SYM_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] len,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
`ifdef SCROLL_REVERSE_EN
  input  logic              dir,
`endif
  output logic [SYM_W-1:0]  hex2,
  output logic [SYM_W-1:0]  hex1,
  output logic [SYM_W-1:0]  hex0,
  output logic [2:0]        dp,
  output logic [2:0]        en,
  output logic              busy,
  output logic              wrap,
  output state_t            state_dbg
);

  logic [SYM_W-1:0]  mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] pos;
  logic [ADDR_W-1:0] last;   // message length minus one
  logic [ADDR_W-1:0] idx1;
  logic [ADDR_W-1:0] idx2;
  logic              tick;
  logic              fwd;

`ifdef SCROLL_REVERSE_EN
  assign fwd = ~dir;
`else
  assign fwd = 1'b1;
`endif

  // Chained single-step wraps give (pos+1) mod L and (pos+2) mod L,
  // which also covers L=1 and L=2 where symbols repeat.
  assign idx1 = next_idx(pos, last);
  assign idx2 = next_idx(idx1, last);

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (state == ST_SCROLL),
    .clr   (start),
    .tick  (tick)
  );

  // Buffer has no reset: contents survive reset and are undefined until written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      pos   <= '0;
      last  <= 4'hF;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
      end else if (start) begin
        state <= ST_SCROLL;
        pos   <= '0;
        last  <= len;
      end else begin
        if (tick) begin
          if (fwd) begin
            pos  <= next_idx(pos, last);
            wrap <= (pos == last);
          end else begin
            pos  <= (pos == '0) ? last : pos - 4'd1;
            wrap <= (pos == '0);
          end
        end
        case (state)
          ST_SCROLL: if (pause)  state <= ST_HOLD;
          ST_HOLD:   if (!pause) state <= ST_SCROLL;
          default:   ;
        endcase
      end
    end
  end

  // Display registers follow pos/state/buffer with one cycle of latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex2 <= SYM_BLANK;
      hex1 <= SYM_BLANK;
      hex0 <= SYM_BLANK;
      en   <= 3'b000;
      dp   <= 3'b000;
    end else begin
      dp <= 3'b000;
      if (state == ST_IDLE) begin
        hex2 <= SYM_BLANK;
        hex1 <= SYM_BLANK;
        hex0 <= SYM_BLANK;
        en   <= 3'b000;
      end else begin
        hex2 <= mem[pos];
        hex1 <= mem[idx1];
        hex0 <= mem[idx2];
        en   <= 3'b111;
      end
    end
  end

endmodule
